axi64_mem_arbiter: RTL
======================

# axi64_mem_arbiter

Two-requester AXI4 (64-bit) arbiter that shares one `axi64` master port between the vector unit's memory engine (requester 0) and a second master (requester 1, e.g. a scalar DMA or CFU-side prefetcher). It arbitrates the AR and AW channels round-robin with per-requester outstanding-burst limits. It tags transaction IDs with the source index, routes R/B responses back by tag, and orders W data by a granted-writer FIFO. It sits between the VFU's AXI signals and the system `axi64` interface.

## Interface
- ID_WIDTH, 6, requester-side ID width; master-side IDs are ID_WIDTH+1.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 64, data width; strobe is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, maximum accepted-but-uncompleted bursts per requester per direction.
- WFIFO_DEPTH, 4, depth of the W-order FIFO (power of two).

Ports (s_* are packed arrays indexed [n], n∈{0,1}):
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_arvalid / s_arready  in / out  [2]  per-requester AR handshake
- s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arcache  in  [2]×ID_WIDTH/ADDR_WIDTH/8/3/2/4  AR payload
- s_rvalid / s_rready  out / in  [2]  per-requester R handshake
- s_rid, s_rdata, s_rresp, s_rlast  out  ID_WIDTH/DATA_WIDTH/2/1  R payload, broadcast to both
- s_awvalid / s_awready, s_aw* payload  in/out, in  same shapes as AR  per-requester AW
- s_wvalid / s_wready  in / out  [2]  per-requester W handshake
- s_wdata, s_wstrb, s_wlast  in  [2]×DATA_WIDTH/DATA_WIDTH/8/1  W payload
- s_bvalid / s_bready  out / in  [2]  per-requester B handshake
- s_bid, s_bresp  out  ID_WIDTH/2  B payload, broadcast
- m_ar*, m_r*, m_aw*, m_w*, m_b*  master side  AXI4 signals to `axi64`; m_arid/m_awid/m_rid/m_bid are ID_WIDTH+1
- busy  out  1  any transaction outstanding or pending

## Operation
- AR stage: one output register. A requester is eligible when s_arvalid=1 and rd_cnt[n] < MAX_OUTSTANDING. Acceptance happens when the register is empty or m_arready=1 in the same cycle. s_arready[winner]=1 only under those conditions.
- Accepted payload is registered; m_arid = {n, s_arid[n]}.
- Round-robin: if both are eligible, grant the requester not granted last. The pointer updates only on an accepted grant. After reset, requester 0 wins ties.
- rd_cnt[n]: +1 on an accepted AR for n; −1 on an R handshake with m_rlast=1 and m_rid[ID_WIDTH]=n; both in the same cycle → unchanged.
- R routing (combinational): sel = m_rid[ID_WIDTH]. s_rvalid[sel]=m_rvalid and the other s_rvalid=0. m_rready=s_rready[sel]. s_rid=m_rid[ID_WIDTH-1:0].
- AW: identical arbiter with its own pointer and wr_cnt. Additional eligibility: the W-order FIFO is not full, or it pops this cycle. Each accepted AW pushes n into the FIFO.
- W routing: FIFO head h selects the source. m_w* = s_w*[h], m_wvalid=s_wvalid[h], s_wready[h]=m_wready, and the other s_wready=0. FIFO empty → m_wvalid=0 and both s_wready=0.
- Pop on a W handshake with s_wlast[h]=1. W beats issued before their AW is granted are stalled (s_wready=0).
- B routing: by m_bid[ID_WIDTH], as for R. wr_cnt[n] −1 on a B handshake for n.
- busy = any rd_cnt/wr_cnt ≠ 0, or FIFO non-empty, or m_arvalid, or m_awvalid.

## Timing
- Reset values: m_arvalid=0, m_awvalid=0, all counters 0, both RR pointers favour requester 0, FIFO empty, busy=0.
- Combinational outputs during reset follow the empty/zero state: s_arready/s_awready=0, s_wready=0, and s_rvalid/s_bvalid follow the master.
- AR/AW latency: accept at cycle t → m_arvalid/m_awvalid high at t+1 and held with stable payload until m_*ready.
- Back-to-back throughput is one burst per cycle per channel when m_*ready stays high.
- R, W and B paths have zero latency and no buffering.
- Counter at MAX_OUTSTANDING blocks only that requester; the other continues to be granted.
- FIFO full with a wlast pop in the same cycle still allows an AW grant.
- Reset mid-burst discards all state. The master side must be reset together; no drain occurs.

## Test plan
- Reset with rst_n=0 for 2 cycles → all m_*valid=0, s_*ready=0, busy=0; requester 0 wins the first tie.
- Both requesters assert AR every cycle, m_arready=1 → grants alternate 0,1,0,1; m_arid MSB alternates; one AR per cycle.
- Requester 0 issues 4 ARs (arlen=0) with no R returned → fifth s_arready[0]=0; requester 1 is still granted. One R with rlast for ID {0,x} → requester 0 is accepted next cycle.
- Interleaved R beats with m_rid={1,5} then {0,3} → delivered to s_rvalid[1] (s_rid=5) then s_rvalid[0] (s_rid=3). m_rready tracks the selected s_rready.
- AW grants 1 then 0 (arlen=3 each); requester 0 presents W first → s_wready[0]=0 until requester 1's 4 beats with wlast complete, then requester 0's beats pass.
- WFIFO_DEPTH=4 AWs granted with W withheld → fifth AW is stalled. A simultaneous wlast pop and AW grant → FIFO count unchanged at 4.

Source files
------------

// File: rtl/axi64_mem_arbiter.sv
// Two-requester AXI4 arbiter onto one axi64 master: round-robin AR/AW with
// outstanding limits, source-tagged IDs, and W ordering by a granted-writer FIFO.
module axi64_arb_chan #(
  parameter int PW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [1:0][PW-1:0]   pld,
  input  logic                 m_ready,
  output logic [1:0]           gnt,
  output logic                 m_valid,
  output logic                 m_src,
  output logic [PW-1:0]        m_pld
);
  logic last, win, accept;

  always_comb begin
    accept = !m_valid || m_ready;
    win    = (req == 2'b11) ? ~last : req[1];
    gnt    = 2'b00;
    if (rst_n && accept && (req != 2'b00)) gnt[win] = 1'b1;
  end

  // last starts at 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_src   <= 1'b0;
      m_pld   <= '0;
      last    <= 1'b1;
    end else if (accept) begin
      m_valid <= |gnt;
      if (|gnt) begin
        m_src <= win;
        m_pld <= pld[win];
        last  <= win;
      end
    end
  end
endmodule

module axi64_mem_arbiter #(
  parameter int ID_WIDTH        = 6,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WFIFO_DEPTH     = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [1:0]                          s_arvalid,
  output logic [1:0]                          s_arready,
  input  logic [1:0][ID_WIDTH-1:0]            s_arid,
  input  logic [1:0][ADDR_WIDTH-1:0]          s_araddr,
  input  logic [1:0][7:0]                     s_arlen,
  input  logic [1:0][2:0]                     s_arsize,
  input  logic [1:0][1:0]                     s_arburst,
  input  logic [1:0][3:0]                     s_arcache,
  output logic [1:0]                          s_rvalid,
  input  logic [1:0]                          s_rready,
  output logic [ID_WIDTH-1:0]                 s_rid,
  output logic [DATA_WIDTH-1:0]               s_rdata,
  output logic [1:0]                          s_rresp,
  output logic                                s_rlast,
  input  logic [1:0]                          s_awvalid,
  output logic [1:0]                          s_awready,
  input  logic [1:0][ID_WIDTH-1:0]            s_awid,
  input  logic [1:0][ADDR_WIDTH-1:0]          s_awaddr,
  input  logic [1:0][7:0]                     s_awlen,
  input  logic [1:0][2:0]                     s_awsize,
  input  logic [1:0][1:0]                     s_awburst,
  input  logic [1:0][3:0]                     s_awcache,
  input  logic [1:0]                          s_wvalid,
  output logic [1:0]                          s_wready,
  input  logic [1:0][DATA_WIDTH-1:0]          s_wdata,
  input  logic [1:0][DATA_WIDTH/8-1:0]        s_wstrb,
  input  logic [1:0]                          s_wlast,
  output logic [1:0]                          s_bvalid,
  input  logic [1:0]                          s_bready,
  output logic [ID_WIDTH-1:0]                 s_bid,
  output logic [1:0]                          s_bresp,
  output logic                                m_arvalid,
  input  logic                                m_arready,
  output logic [ID_WIDTH:0]                   m_arid,
  output logic [ADDR_WIDTH-1:0]               m_araddr,
  output logic [7:0]                          m_arlen,
  output logic [2:0]                          m_arsize,
  output logic [1:0]                          m_arburst,
  output logic [3:0]                          m_arcache,
  input  logic                                m_rvalid,
  output logic                                m_rready,
  input  logic [ID_WIDTH:0]                   m_rid,
  input  logic [DATA_WIDTH-1:0]               m_rdata,
  input  logic [1:0]                          m_rresp,
  input  logic                                m_rlast,
  output logic                                m_awvalid,
  input  logic                                m_awready,
  output logic [ID_WIDTH:0]                   m_awid,
  output logic [ADDR_WIDTH-1:0]               m_awaddr,
  output logic [7:0]                          m_awlen,
  output logic [2:0]                          m_awsize,
  output logic [1:0]                          m_awburst,
  output logic [3:0]                          m_awcache,
  output logic                                m_wvalid,
  input  logic                                m_wready,
  output logic [DATA_WIDTH-1:0]               m_wdata,
  output logic [DATA_WIDTH/8-1:0]             m_wstrb,
  output logic                                m_wlast,
  input  logic                                m_bvalid,
  output logic                                m_bready,
  input  logic [ID_WIDTH:0]                   m_bid,
  input  logic [1:0]                          m_bresp,
  output logic                                busy
);
  localparam int PW  = ID_WIDTH + ADDR_WIDTH + 17;
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW  = $clog2(WFIFO_DEPTH);
  localparam int FW1 = FW + 1;
  localparam logic [CW-1:0]  CMAX = CW'(MAX_OUTSTANDING);
  localparam logic [FW:0]    WDEP = FW1'(WFIFO_DEPTH);

  logic [1:0][PW-1:0] ar_pld, aw_pld;
  logic [PW-1:0]      ar_m, aw_m;
  logic               ar_src, aw_src;
  logic [1:0]         ar_req, aw_req, rd_done, wr_done;
  logic [1:0][CW-1:0] rd_cnt, wr_cnt;

  logic [WFIFO_DEPTH-1:0] wf_mem;
  logic [FW:0]            wf_wp, wf_rp, wf_cnt;
  logic                   wf_full, wf_empty, wf_pop, wf_head;

  assign wf_cnt   = wf_wp - wf_rp;
  assign wf_full  = (wf_cnt == WDEP);
  assign wf_empty = (wf_cnt == '0);
  assign wf_head  = wf_mem[wf_rp[FW-1:0]];
  assign wf_pop   = !wf_empty && s_wvalid[wf_head] && m_wready && s_wlast[wf_head];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      ar_pld[n]  = {s_arid[n], s_araddr[n], s_arlen[n], s_arsize[n], s_arburst[n], s_arcache[n]};
      aw_pld[n]  = {s_awid[n], s_awaddr[n], s_awlen[n], s_awsize[n], s_awburst[n], s_awcache[n]};
      rd_done[n] = m_rvalid && m_rready && m_rlast && (m_rid[ID_WIDTH] == 1'(n));
      wr_done[n] = m_bvalid && m_bready && (m_bid[ID_WIDTH] == 1'(n));
      ar_req[n]  = s_arvalid[n] && (rd_cnt[n] < CMAX);
      // a wlast pop frees a FIFO slot in the same cycle
      aw_req[n]  = s_awvalid[n] && (wr_cnt[n] < CMAX) && (!wf_full || wf_pop);
    end
  end

  axi64_arb_chan #(.PW(PW)) u_ar (
    .clk(clk), .rst_n(rst_n), .req(ar_req), .pld(ar_pld), .m_ready(m_arready),
    .gnt(s_arready), .m_valid(m_arvalid), .m_src(ar_src), .m_pld(ar_m)
  );
  axi64_arb_chan #(.PW(PW)) u_aw (
    .clk(clk), .rst_n(rst_n), .req(aw_req), .pld(aw_pld), .m_ready(m_awready),
    .gnt(s_awready), .m_valid(m_awvalid), .m_src(aw_src), .m_pld(aw_m)
  );

  assign m_arid = {ar_src, ar_m[PW-1 -: ID_WIDTH]};
  assign {m_araddr, m_arlen, m_arsize, m_arburst, m_arcache} = ar_m[PW-ID_WIDTH-1:0];
  assign m_awid = {aw_src, aw_m[PW-1 -: ID_WIDTH]};
  assign {m_awaddr, m_awlen, m_awsize, m_awburst, m_awcache} = aw_m[PW-ID_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
      wf_mem <= '0;
      wf_wp  <= '0;
      wf_rp  <= '0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        rd_cnt[n] <= rd_cnt[n] + CW'(s_arready[n]) - CW'(rd_done[n]);
        wr_cnt[n] <= wr_cnt[n] + CW'(s_awready[n]) - CW'(wr_done[n]);
      end
      if (|s_awready) begin
        wf_mem[wf_wp[FW-1:0]] <= s_awready[1];
        wf_wp <= wf_wp + FW1'(1);
      end
      if (wf_pop) wf_rp <= wf_rp + FW1'(1);
    end
  end

  always_comb begin
    s_rvalid = 2'b00;
    s_rvalid[m_rid[ID_WIDTH]] = m_rvalid;
    m_rready = s_rready[m_rid[ID_WIDTH]];
    s_rid    = m_rid[ID_WIDTH-1:0];
    s_rdata  = m_rdata;
    s_rresp  = m_rresp;
    s_rlast  = m_rlast;

    s_bvalid = 2'b00;
    s_bvalid[m_bid[ID_WIDTH]] = m_bvalid;
    m_bready = s_bready[m_bid[ID_WIDTH]];
    s_bid    = m_bid[ID_WIDTH-1:0];
    s_bresp  = m_bresp;

    // W beats follow AW grant order; a writer not at the head is stalled
    m_wvalid = !wf_empty && s_wvalid[wf_head];
    m_wdata  = s_wdata[wf_head];
    m_wstrb  = s_wstrb[wf_head];
    m_wlast  = s_wlast[wf_head];
    s_wready = 2'b00;
    if (rst_n && !wf_empty) s_wready[wf_head] = m_wready;

    busy = (|rd_cnt) || (|wr_cnt) || !wf_empty || m_arvalid || m_awvalid;
  end
endmodule
